// File: rtl/rv_imem_boot_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package rv_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_ERR    = 3'd5
   } boot_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_LEN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // States in which a frame is being received and the inter-byte timer runs.
   function automatic logic is_active(input boot_state_e s);
      return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/rv_imem_boot_loader_if.sv
// UART RX byte stream in, instruction-memory write/address port out.
interface rv_imem_boot_loader_if #(
   parameter int ADDR_W = 10
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [7:0]        imem_wdata;

   // Boot loader side: consumes bytes, drives the memory port.
   modport master (
      input  rx_valid,
      input  rx_data,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   // UART / memory side.
   modport slave (
      output rx_valid,
      output rx_data,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

// File: rtl/rv_imem_boot_loader_timeout.sv
// Inter-byte timeout: down-counter reloaded on every received byte and while
// disabled; pulses expire in the cycle the count would pass zero.
module rv_boot_timeout #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload on a byte or when idle, otherwise count down and stick at zero.
   always_comb begin
      cnt_d  = cnt_q;
      expire = 1'b0;
      if (!en || clr) begin
         cnt_d = LOAD_V;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         expire = 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= LOAD_V;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rv_imem_boot_loader.sv
// UART boot loader: parses SYNC/LEN/payload/CSUM frames, writes the payload
// into instruction memory from address 0 and holds the CPU in reset meanwhile.
module rv_imem_boot_loader
   import rv_boot_pkg::*;
#(
   parameter int         ADDR_W      = 10,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYC = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     cpu_pc,
   rv_imem_boot_loader_if.master bus,
   output logic                  cpu_rst_n,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err,
   output logic [1:0]            err_code,
   output logic [ADDR_W:0]       bytes_written
);
   // Lengths are compared at 17 bits so 2^16-1 never aliases the capacity.
   localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

   boot_state_e       state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [15:0]       len_q, len_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W:0]   bytes_written_q, bytes_written_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              tmo_expire;
   logic              sync_seen;
   logic              fail;
   logic [1:0]        fail_code;
   logic [16:0]       len_full;
   logic [ADDR_W:0]   bw_next;

   rv_boot_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (is_active(state_q)),
      .clr    (bus.rx_valid),
      .expire (tmo_expire)
   );

   assign sync_seen = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
   assign len_full  = {1'b0, bus.rx_data, len_lo_q};
   assign bw_next   = bytes_written_q + (ADDR_W+1)'(1);

   // Frame parser: next state, write stage, checksum and status flags.
   always_comb begin
      state_d         = state_q;
      len_lo_d        = len_lo_q;
      len_d           = len_q;
      csum_d          = csum_q;
      bytes_written_d = bytes_written_q;
      we_d            = 1'b0;
      waddr_d         = waddr_q;
      wdata_d         = wdata_q;
      cpu_rst_n_d     = cpu_rst_n_q;
      busy_d          = busy_q;
      done_d          = done_q;
      err_d           = err_q;
      err_code_d      = err_code_q;
      fail            = 1'b0;
      fail_code       = ERR_NONE;

      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (sync_seen) begin
               state_d         = ST_LEN_LO;
               cpu_rst_n_d     = 1'b0;
               busy_d          = 1'b1;
               done_d          = 1'b0;
               err_d           = 1'b0;
               err_code_d      = ERR_NONE;
               bytes_written_d = '0;
               csum_d          = '0;
               waddr_d         = '0;
            end else begin
               // A failed image must never run; a clean idle releases the CPU.
               cpu_rst_n_d = (state_q == ST_IDLE);
            end
         end
         ST_LEN_LO: begin
            if (bus.rx_valid) begin
               len_lo_d = bus.rx_data;
               state_d  = ST_LEN_HI;
            end else if (tmo_expire) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         ST_LEN_HI: begin
            if (bus.rx_valid) begin
               if (len_full > CAPACITY) begin
                  fail      = 1'b1;
                  fail_code = ERR_LEN;
               end else begin
                  len_d   = len_full[15:0];
                  state_d = (len_full == 17'd0) ? ST_CSUM : ST_DATA;
               end
            end else if (tmo_expire) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         ST_DATA: begin
            if (bus.rx_valid) begin
               // The write lands one cycle later at the pre-increment pointer.
               we_d            = 1'b1;
               waddr_d         = bytes_written_q[ADDR_W-1:0];
               wdata_d         = bus.rx_data;
               bytes_written_d = bw_next;
               csum_d          = csum_q + bus.rx_data;
               if (17'(bw_next) == {1'b0, len_q}) begin
                  state_d = ST_CSUM;
               end
            end else if (tmo_expire) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         ST_CSUM: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == csum_q) begin
                  state_d     = ST_IDLE;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  cpu_rst_n_d = 1'b1;
               end else begin
                  fail      = 1'b1;
                  fail_code = ERR_CSUM;
               end
            end else if (tmo_expire) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fail) begin
         state_d     = ST_ERR;
         err_d       = 1'b1;
         err_code_d  = fail_code;
         busy_d      = 1'b0;
         cpu_rst_n_d = 1'b0;
      end
   end

   // State and datapath registers; reset abandons any load in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         len_lo_q        <= '0;
         len_q           <= '0;
         csum_q          <= '0;
         bytes_written_q <= '0;
         we_q            <= 1'b0;
         waddr_q         <= '0;
         wdata_q         <= '0;
         cpu_rst_n_q     <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         err_code_q      <= ERR_NONE;
      end else begin
         state_q         <= state_d;
         len_lo_q        <= len_lo_d;
         len_q           <= len_d;
         csum_q          <= csum_d;
         bytes_written_q <= bytes_written_d;
         we_q            <= we_d;
         waddr_q         <= waddr_d;
         wdata_q         <= wdata_d;
         cpu_rst_n_q     <= cpu_rst_n_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         err_q           <= err_d;
         err_code_q      <= err_code_d;
      end
   end

   // Fetch owns the address port only when idle with no trailing write pending.
   assign bus.imem_addr  = ((state_q != ST_IDLE) || we_q) ? waddr_q : cpu_pc;
   assign bus.imem_we    = we_q;
   assign bus.imem_wdata = wdata_q;

   assign cpu_rst_n     = cpu_rst_n_q;
   assign busy          = busy_q;
   assign load_done     = done_q;
   assign load_err      = err_q;
   assign err_code      = err_code_q;
   assign bytes_written = bytes_written_q;

endmodule

// File: doc/rv_imem_boot_loader.md
Name: rv_imem_boot_loader

Overview:
UART boot controller for the byte-writable instruction memory. It receives a framed program image from the UART RX byte stream and writes it byte-by-byte into instruction memory starting at address 0. It arbitrates the instruction-memory address port between itself and the CPU fetch PC, and holds the CPU in reset while loading or after a failed load.

Parameters:
ADDR_W, 10, instruction memory byte-address width; capacity is 2^ADDR_W bytes
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles (bench overrides to 64)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle pulse, rx_data valid; back-to-back pulses legal
rx_data  input  8  received UART byte
cpu_pc  input  ADDR_W  CPU fetch byte address
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  instruction memory byte address (muxed)
imem_wdata  output  8  write byte
cpu_rst_n  output  1  active-low CPU reset
busy  output  1  load in progress
load_done  output  1  last load succeeded (sticky until next SYNC)
load_err  output  1  last load failed (sticky until next SYNC)
err_code  output  2  0 none, 1 checksum, 2 length overflow, 3 timeout
bytes_written  output  ADDR_W+1  payload bytes written in current/last load

Behaviour:
- Frame: SYNC_BYTE, LEN_LO, LEN_HI (16-bit byte count, little-endian), LEN payload bytes, CSUM (payload sum mod 256).
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR. Reset -> IDLE.
- Reset values: imem_we=0, imem_wdata=0, cpu_rst_n=0, busy=0, load_done=0, load_err=0, err_code=0, bytes_written=0. cpu_rst_n registered; goes 1 on first clk edge after rst_n deasserts.
- IDLE: cpu_rst_n=1. Non-SYNC bytes are ignored. SYNC -> LEN_LO; cpu_rst_n=0, busy=1, load_done/load_err/err_code/bytes_written/checksum/write pointer cleared, all on the same edge.
- LEN_LO -> LEN_HI on a byte.
- LEN_HI on a byte:
  - LEN > 2^ADDR_W -> ERR, err_code=2.
  - LEN==0 -> CSUM.
  - Otherwise -> DATA.
- DATA: byte accepted in cycle N -> in cycle N+1 imem_we=1, imem_addr=wptr, imem_wdata=byte. wptr and bytes_written increment and checksum accumulates at the N edge. After byte LEN -> CSUM. SYNC_BYTE in DATA is ordinary data.
- CSUM: received byte == checksum -> IDLE, load_done=1, busy=0, cpu_rst_n=1 at the next edge. Mismatch -> ERR, err_code=1.
- ERR: cpu_rst_n=0, busy=0, load_err=1. Only SYNC leaves ERR (-> LEN_LO). The image is treated as corrupt and the CPU never runs it.
- Timeout: in LEN_LO/LEN_HI/DATA/CSUM, a counter resets on every rx_valid. Reaching TIMEOUT_CYC -> ERR, err_code=3. rx_valid in the expiry cycle wins: the byte is accepted and no timeout occurs.
- Address mux: imem_addr = write address when state!=IDLE or imem_we=1, else cpu_pc. Combinational from state/regs; no added latency on the fetch path.
- Only one imem write per accepted byte. imem_we is never asserted in IDLE except for the trailing write of the final payload byte.
- Reset mid-load: immediate return to reset values. Memory keeps any bytes already written and is not rolled back.
- Width rules: LEN compared as 17-bit against 2^ADDR_W. The write pointer never exceeds 2^ADDR_W-1, so no wrap occurs.

Decomposition:
- Package rv_boot_pkg: state encodings, ERR_NONE/ERR_CSUM/ERR_LEN/ERR_TIMEOUT constants, default SYNC_BYTE.
- Sub-module rv_boot_timeout: loadable down-counter with clear on rx_valid, enable in active states, one-cycle expire output.
- The remaining FSM, checksum, write stage and mux live in the top module.

Test Plan:
- Reset, no rx -> cpu_rst_n=1 one edge after rst_n high; imem_addr tracks cpu_pc=0x04C; imem_we never 1.
- Frame A5 04 00 13 05 00 00 (CSUM 18) -> four writes, addr 0..3 with data 13,05,00,00, each one cycle after its rx_valid. load_done=1, bytes_written=4, cpu_rst_n=0 during load and 1 after CSUM. Readback of word at addr 0 = 0x00000513.
- Same frame with CSUM 19 -> ERR, err_code=1, load_err=1, cpu_rst_n stays 0. A following good frame recovers with load_done=1, err_code=0.
- Length 0x0401 (A5 01 04) -> ERR, err_code=2 on the LEN_HI edge; no writes.
- TIMEOUT_CYC=64, stall 64 cycles after 2 payload bytes -> ERR, err_code=3, bytes_written=2. With a byte arriving exactly in the expiry cycle -> no error.
- Back-to-back rx_valid every cycle for an 8-byte payload -> 8 consecutive imem_we cycles with correct addresses. rst_n pulsed low mid-DATA -> all outputs at reset values, state IDLE.
